vic_vect_sched: RTL and testbench

Vectored IRQ scheduler for the VIC. It sits downstream of the interrupt generator and consumes its `IRQStatus`/`FIQStatus` vectors. It maps enabled sources onto `NUM_VECT` fixed-priority vector slots, drives the active-low `nIRQ`/`nFIQ` lines to the core, and supplies the `VICVectAddr` read value. It also tracks nested in-service priority levels between vector-address reads (acknowledge) and vector-address writes (end of interrupt, EOI).

---
 rtl/vic_vect_sched_pkg.sv | 8 +
 rtl/vic_vect_sched_if.sv | 19 +
 rtl/vic_prio_enc.sv | 16 +
 rtl/vic_vect_sched.sv | 63 ++++++
 tb/tb_vic_vect_sched.sv | 132 +++++++++++++
 5 files changed

// File: rtl/vic_vect_sched_pkg.sv
// vic_vect_sched_pkg: shared VIC constants and VectCntl field layout
package vic_vect_sched_pkg;
  localparam int VIC_NUM_SRC = 32;
  localparam int VIC_SRC_W = 5;
  localparam int VIC_CNTL_W = 6;
  localparam int VIC_CNTL_EN = 5;
  localparam int VIC_CNTL_SRC = 0;
endpackage

// File: rtl/vic_vect_sched_if.sv
// vic_vect_sched_if: request, acknowledge/EOI and core-facing signals of the vector scheduler
interface vic_vect_sched_if #(parameter int NUM_VECT = 16);
  logic [31:0] IRQStatus;
  logic [31:0] FIQStatus;
  logic vect_addr_rd;
  logic vect_addr_wr;
  logic [31:0] sched_reg_VICVectAddr;
  logic nIRQ;
  logic nFIQ;
  logic [NUM_VECT:0] in_service;
  modport master (
    output IRQStatus, FIQStatus, vect_addr_rd, vect_addr_wr,
    input  sched_reg_VICVectAddr, nIRQ, nFIQ, in_service
  );
  modport slave (
    input  IRQStatus, FIQStatus, vect_addr_rd, vect_addr_wr,
    output sched_reg_VICVectAddr, nIRQ, nFIQ, in_service
  );
endinterface

// File: rtl/vic_prio_enc.sv
// vic_prio_enc: lowest-index-set encoder; idx = W when empty, valid only below ceil
module vic_prio_enc #(
  parameter int W = 17,
  parameter int IW = $clog2(W + 1)
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] ceil,
  output logic [IW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = IW'(W);
    for (int i = W - 1; i >= 0; i--) idx = req[i] ? IW'(i) : idx;
  end
  assign valid = idx < ceil;
endmodule

// File: rtl/vic_vect_sched.sv
// vic_vect_sched: vectored IRQ slot scheduler with nested in-service tracking and FIQ pass-through
module vic_vect_sched
  import vic_vect_sched_pkg::*;
#(
  parameter int NUM_VECT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_VECT*VIC_CNTL_W-1:0] top_reg_VICVectCntl,
  input  logic [NUM_VECT*32-1:0]         top_reg_VICVectAddr,
  input  logic [31:0]                    top_reg_VICDefVectAddr,
  vic_vect_sched_if.slave                bus
);
  localparam int W = NUM_VECT + 1;
  localparam int IW = $clog2(W + 1);
  logic [NUM_VECT-1:0] hit;
  logic [VIC_NUM_SRC-1:0] claimed;
  logic [W-1:0] req, isv, isv_pop, isv_next;
  logic [IW-1:0] ceil_idx, cand_idx, nceil_idx;
  logic isv_any, cand_v, nxt_any;
  logic [31:0] addr, addr_next;
  logic nirq, nfiq;
  function automatic logic [31:0] addr_of(input logic [IW-1:0] i);
    return 32'(i) < NUM_VECT ? top_reg_VICVectAddr[32*i +: 32] : top_reg_VICDefVectAddr;
  endfunction
  always_comb begin
    hit = '0;
    claimed = '0;
    for (int i = 0; i < NUM_VECT; i++) begin
      hit[i] = top_reg_VICVectCntl[i*VIC_CNTL_W+VIC_CNTL_EN]
             & bus.IRQStatus[top_reg_VICVectCntl[i*VIC_CNTL_W+VIC_CNTL_SRC +: VIC_SRC_W]];
      claimed[top_reg_VICVectCntl[i*VIC_CNTL_W+VIC_CNTL_SRC +: VIC_SRC_W]] =
        claimed[top_reg_VICVectCntl[i*VIC_CNTL_W+VIC_CNTL_SRC +: VIC_SRC_W]]
        | top_reg_VICVectCntl[i*VIC_CNTL_W+VIC_CNTL_EN];
    end
  end
  assign req = {|(bus.IRQStatus & ~claimed), hit};
  vic_prio_enc #(.W(W)) u_ceil (.req(isv), .ceil(IW'(W)), .idx(ceil_idx), .valid(isv_any));
  vic_prio_enc #(.W(W)) u_cand (.req(req), .ceil(ceil_idx), .idx(cand_idx), .valid(cand_v));
  vic_prio_enc #(.W(W)) u_next (.req(isv_next), .ceil(IW'(W)), .idx(nceil_idx), .valid(nxt_any));
  // pop uses the pre-pop ceiling, push uses the candidate chosen against the pre-pop mask
  assign isv_pop = bus.vect_addr_wr ? isv & ~(W'(1) << ceil_idx) : isv;
  assign isv_next = bus.vect_addr_rd && cand_v ? isv_pop | (W'(1) << cand_idx) : isv_pop;
  assign addr_next = bus.vect_addr_rd ? addr_of(cand_v ? cand_idx : IW'(NUM_VECT))
                   : bus.vect_addr_wr && isv_any ? addr_of(nxt_any ? nceil_idx : IW'(NUM_VECT))
                   : addr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      isv <= '0;
      addr <= '0;
      nirq <= 1'b1;
      nfiq <= 1'b1;
    end else begin
      isv <= isv_next;
      addr <= addr_next;
      nirq <= ~(cand_idx < nceil_idx);
      nfiq <= ~|bus.FIQStatus;
    end
  assign bus.in_service = isv;
  assign bus.sched_reg_VICVectAddr = addr;
  assign bus.nIRQ = nirq;
  assign bus.nFIQ = nfiq;
endmodule

// File: tb/tb_vic_vect_sched.sv
// tb_vic_vect_sched: directed vectors for vectored IRQ scheduling, nesting, default/spurious and reset
module tb_vic_vect_sched;
  localparam int NV = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NV*6-1:0] cntl;
  logic [NV*32-1:0] vaddr;
  logic [31:0] def;
  int n_cmp = 0;
  int n_bad = 0;
  vic_vect_sched_if #(.NUM_VECT(NV)) bus ();
  vic_vect_sched #(.NUM_VECT(NV)) dut (
    .clk(clk),
    .rst(rst),
    .top_reg_VICVectCntl(cntl),
    .top_reg_VICVectAddr(vaddr),
    .top_reg_VICDefVectAddr(def),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic r, input logic w);
    bus.vect_addr_rd = r;
    bus.vect_addr_wr = w;
    step();
    bus.vect_addr_rd = 1'b0;
    bus.vect_addr_wr = 1'b0;
  endtask
  initial begin
    cntl = '0;
    cntl[3*6 +: 6] = 6'h27;
    cntl[1*6 +: 6] = 6'h29;
    cntl[5*6 +: 6] = 6'h2B;
    vaddr = '0;
    vaddr[3*32 +: 32] = 32'h0000_1300;
    vaddr[1*32 +: 32] = 32'h0000_1100;
    vaddr[5*32 +: 32] = 32'h0000_1500;
    def = 32'h0000_DEF0;
    bus.IRQStatus = '0;
    bus.FIQStatus = '0;
    bus.vect_addr_rd = 1'b0;
    bus.vect_addr_wr = 1'b0;
    step();
    chk("rst_isv", 32'(bus.in_service), 32'h0);
    chk("rst_addr", bus.sched_reg_VICVectAddr, 32'h0);
    chk("rst_nirq", 32'(bus.nIRQ), 32'h1);
    chk("rst_nfiq", 32'(bus.nFIQ), 32'h1);
    rst = 1'b1;
    step();
    chk("idle_nirq", 32'(bus.nIRQ), 32'h1);
    bus.IRQStatus = 32'h1 << 7;
    chk("nirq_registered", 32'(bus.nIRQ), 32'h1);
    step();
    chk("single_nirq", 32'(bus.nIRQ), 32'h0);
    pulse(1'b1, 1'b0);
    chk("single_addr", bus.sched_reg_VICVectAddr, 32'h1300);
    chk("single_isv", 32'(bus.in_service), 32'h8);
    chk("single_ack_nirq", 32'(bus.nIRQ), 32'h1);
    bus.IRQStatus |= 32'h1 << 11;
    step();
    chk("lower_blocked", 32'(bus.nIRQ), 32'h1);
    bus.IRQStatus |= 32'h1 << 9;
    step();
    chk("nest_nirq", 32'(bus.nIRQ), 32'h0);
    pulse(1'b1, 1'b0);
    chk("nest_addr", bus.sched_reg_VICVectAddr, 32'h1100);
    chk("nest_isv", 32'(bus.in_service), 32'hA);
    chk("nest_ack_nirq", 32'(bus.nIRQ), 32'h1);
    pulse(1'b0, 1'b1);
    chk("eoi_isv", 32'(bus.in_service), 32'h8);
    chk("eoi_addr", bus.sched_reg_VICVectAddr, 32'h1300);
    chk("eoi_reassert", 32'(bus.nIRQ), 32'h0);
    pulse(1'b1, 1'b1);
    chk("rdwr_isv", 32'(bus.in_service), 32'h2);
    chk("rdwr_addr", bus.sched_reg_VICVectAddr, 32'h1100);
    chk("rdwr_nirq", 32'(bus.nIRQ), 32'h1);
    bus.IRQStatus = '0;
    pulse(1'b0, 1'b1);
    chk("eoi_empty_isv", 32'(bus.in_service), 32'h0);
    chk("eoi_empty_addr", bus.sched_reg_VICVectAddr, 32'hDEF0);
    chk("eoi_empty_nirq", 32'(bus.nIRQ), 32'h1);
    def = 32'h0000_BEEF;
    pulse(1'b1, 1'b0);
    chk("spur_addr", bus.sched_reg_VICVectAddr, 32'hBEEF);
    chk("spur_isv", 32'(bus.in_service), 32'h0);
    chk("spur_nirq", 32'(bus.nIRQ), 32'h1);
    def = 32'h0000_DEF0;
    pulse(1'b0, 1'b1);
    chk("wr_noop_isv", 32'(bus.in_service), 32'h0);
    chk("wr_noop_addr", bus.sched_reg_VICVectAddr, 32'hBEEF);
    bus.IRQStatus = 32'h1 << 20;
    step();
    chk("def_nirq", 32'(bus.nIRQ), 32'h0);
    pulse(1'b1, 1'b0);
    chk("def_addr", bus.sched_reg_VICVectAddr, 32'hDEF0);
    chk("def_isv", 32'(bus.in_service), 32'h1_0000);
    chk("def_ack_nirq", 32'(bus.nIRQ), 32'h1);
    bus.IRQStatus |= 32'h1 << 7;
    bus.FIQStatus = 32'h4;
    step();
    chk("over_def_nirq", 32'(bus.nIRQ), 32'h0);
    chk("fiq_nfiq", 32'(bus.nFIQ), 32'h0);
    pulse(1'b1, 1'b0);
    chk("over_def_addr", bus.sched_reg_VICVectAddr, 32'h1300);
    chk("over_def_isv", 32'(bus.in_service), 32'h1_0008);
    chk("over_def_ack_nirq", 32'(bus.nIRQ), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_isv", 32'(bus.in_service), 32'h0);
    chk("mid_rst_addr", bus.sched_reg_VICVectAddr, 32'h0);
    chk("mid_rst_nirq", 32'(bus.nIRQ), 32'h1);
    chk("mid_rst_nfiq", 32'(bus.nFIQ), 32'h1);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_nfiq", 32'(bus.nFIQ), 32'h0);
    chk("post_rst_nirq", 32'(bus.nIRQ), 32'h0);
    chk("post_rst_isv", 32'(bus.in_service), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
